// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state encoding and bus constants for the memory stage
package mips_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int ADDR_W = 15;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_t;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    // Byte lane selection follows the low address bit for byte accesses.
    function automatic logic [1:0] byte_enable(input logic word_en, input logic addr0);
        if (word_en) begin
            return BE_WORD;
        end
        return addr0 ? BE_HI : BE_LO;
    endfunction

    // Byte stores replicate the byte on both lanes so the enables alone pick the lane.
    function automatic logic [DATA_W-1:0] store_data(input logic word_en,
                                                     input logic [DATA_W-1:0] data);
        if (word_en) begin
            return data;
        end
        return {data[7:0], data[7:0]};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory req/ack bus between the memory stage and data memory
interface mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [14:0] dmem_addr;
    logic [1:0]  dmem_be;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - lane select and sign/zero extension of load data
module load_align
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic              addr0,
    input  logic              word_en,
    input  logic              ld_en,
    output logic [DATA_W-1:0] data
);

    logic [7:0] w_byte;
    logic       w_sign;

    assign w_byte = addr0 ? rdata[15:8] : rdata[7:0];
    assign w_sign = ld_en & w_byte[7];
    assign data   = word_en ? rdata : {{8{w_sign}}, w_byte};

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory access stage: dmem req/ack FSM, pipeline stall and MEM/WB register
module mem_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              word_en,
    input  logic              ld_en,
    input  logic              memtoreg,
    input  logic              reg_write,
    input  logic              halt,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] reg_out,
    input  logic [REG_W-1:0]  instr_rd,

    mem_stage_if.master       dmem,

    output logic              stall,
    output logic              memtoreg_wb,
    output logic              reg_write_wb,
    output logic              halt_wb,
    output logic [REG_W-1:0]  instr_rd_wb,
    output logic [DATA_W-1:0] alu_out_wb,
    output logic [DATA_W-1:0] mem_data_wb,
    output logic              misalign_err
);

    mem_state_t r_state;
    mem_state_t w_next;

    logic w_mem_op;
    logic w_misalign;
    logic w_misalign_idle;
    logic w_access;
    logic w_is_load;
    logic w_stall;
    logic w_start;
    logic w_done;

    logic [DATA_W-1:0] w_ld_data;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_be;
    logic [DATA_W-1:0] r_wdata;

    logic              r_memtoreg_wb;
    logic              r_reg_write_wb;
    logic              r_halt_wb;
    logic [REG_W-1:0]  r_instr_rd_wb;
    logic [DATA_W-1:0] r_alu_out_wb;
    logic [DATA_W-1:0] r_mem_data_wb;
    logic              r_misalign_err;

    assign w_mem_op        = mem_read | mem_write;
    assign w_misalign      = w_mem_op & word_en & alu_out[0];
    assign w_access        = w_mem_op & ~w_misalign;
    assign w_misalign_idle = (r_state == MEM_IDLE) & w_misalign;
    // A simultaneous read and write is executed as a write and returns no load data.
    assign w_is_load       = mem_read & ~mem_write;

    load_align u_load_align (
        .rdata   (dmem.dmem_rdata),
        .addr0   (alu_out[0]),
        .word_en (word_en),
        .ld_en   (ld_en),
        .data    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_start = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (w_access) begin
                    w_next  = MEM_ACCESS;
                    w_stall = 1'b1;
                    w_start = 1'b1;
                end
            end
            MEM_ACCESS: begin
                if (dmem.dmem_ack) begin
                    w_next = MEM_IDLE;
                    w_done = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next = MEM_IDLE;
        endcase
        if (!rst_n) begin
            w_stall = 1'b0;
        end
    end

    assign stall = w_stall;

    // Bus registers only move when entering or leaving ACCESS, keeping the request stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= mem_write;
            r_addr  <= alu_out[DATA_W-1:1];
            r_be    <= byte_enable(word_en, alu_out[0]);
            r_wdata <= store_data(word_en, reg_out);
        end else if (w_done) begin
            r_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_memtoreg_wb  <= 1'b0;
            r_reg_write_wb <= 1'b0;
            r_halt_wb      <= 1'b0;
            r_instr_rd_wb  <= '0;
            r_alu_out_wb   <= '0;
            r_mem_data_wb  <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= w_misalign_idle;
            if (w_stall) begin
                r_memtoreg_wb  <= 1'b0;
                r_reg_write_wb <= 1'b0;
                r_halt_wb      <= 1'b0;
            end else begin
                r_memtoreg_wb  <= memtoreg & ~w_misalign_idle;
                r_reg_write_wb <= reg_write & ~w_misalign_idle;
                r_halt_wb      <= halt;
                r_instr_rd_wb  <= instr_rd;
                r_alu_out_wb   <= alu_out;
                r_mem_data_wb  <= (w_done & w_is_load) ? w_ld_data : '0;
            end
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;

    assign memtoreg_wb  = r_memtoreg_wb;
    assign reg_write_wb = r_reg_write_wb;
    assign halt_wb      = r_halt_wb;
    assign instr_rd_wb  = r_instr_rd_wb;
    assign alu_out_wb   = r_alu_out_wb;
    assign mem_data_wb  = r_mem_data_wb;
    assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a behavioural memory responder
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, word_en, ld_en, memtoreg, reg_write, halt;
    logic [15:0] alu_out, reg_out;
    logic [2:0]  instr_rd;
    logic        stall, memtoreg_wb, reg_write_wb, halt_wb, misalign_err;
    logic [2:0]  instr_rd_wb;
    logic [15:0] alu_out_wb, mem_data_wb;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .word_en      (word_en),
        .ld_en        (ld_en),
        .memtoreg     (memtoreg),
        .reg_write    (reg_write),
        .halt         (halt),
        .alu_out      (alu_out),
        .reg_out      (reg_out),
        .instr_rd     (instr_rd),
        .dmem         (dmem_bus),
        .stall        (stall),
        .memtoreg_wb  (memtoreg_wb),
        .reg_write_wb (reg_write_wb),
        .halt_wb      (halt_wb),
        .instr_rd_wb  (instr_rd_wb),
        .alu_out_wb   (alu_out_wb),
        .mem_data_wb  (mem_data_wb),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          o_stall_cnt;
    logic        o_req_seen, o_unstable, o_timeout;
    logic        o_we;
    logic [14:0] o_addr;
    logic [1:0]  o_be;
    logic [15:0] o_wdata;

    // Reference load result computed directly from the lane/extension rules.
    function automatic logic [15:0] model_load(input logic [15:0] rdata, input logic [15:0] addr,
                                               input logic wen, input logic lde);
        int b;
        if (wen) return rdata;
        b = addr[0] ? int'(rdata) / 256 : int'(rdata) % 256;
        if (lde && b >= 128) b = b + 16'hFF00;
        return 16'(b);
    endfunction

    task automatic set_nop();
        mem_read = 0; mem_write = 0; word_en = 1; ld_en = 0;
        memtoreg = 0; reg_write = 0; halt = 0;
        alu_out = 16'h0; reg_out = 16'h0; instr_rd = 3'd0;
    endtask

    // Presents one instruction and plays memory: ack after lat cycles of dmem_req.
    task automatic run_op(input logic mr, input logic mw, input logic wen, input logic lde,
                          input logic mtr, input logic rw, input logic hlt,
                          input logic [15:0] addr, input logic [15:0] rout, input logic [2:0] rd,
                          input logic [15:0] rdata, input int lat, input logic idle_ack);
        int cnt, cyc;
        logic done;
        @(negedge clk);
        mem_read = mr; mem_write = mw; word_en = wen; ld_en = lde;
        memtoreg = mtr; reg_write = rw; halt = hlt;
        alu_out = addr; reg_out = rout; instr_rd = rd;
        dmem_bus.dmem_rdata = rdata;
        o_stall_cnt = 0; o_req_seen = 0; o_unstable = 0; o_timeout = 0;
        cnt = 0; cyc = 0; done = 0;
        while (!done && cyc < 64) begin
            if (cyc > 0) @(negedge clk);
            if (dmem_bus.dmem_req) begin
                if (!o_req_seen) begin
                    o_we = dmem_bus.dmem_we; o_addr = dmem_bus.dmem_addr;
                    o_be = dmem_bus.dmem_be; o_wdata = dmem_bus.dmem_wdata;
                end else if (o_we !== dmem_bus.dmem_we || o_addr !== dmem_bus.dmem_addr ||
                             o_be !== dmem_bus.dmem_be || o_wdata !== dmem_bus.dmem_wdata) begin
                    o_unstable = 1;
                end
                o_req_seen = 1;
                dmem_bus.dmem_ack = (cnt == lat);
                cnt++;
            end else begin
                dmem_bus.dmem_ack = idle_ack;
            end
            #1;
            if (stall) o_stall_cnt++;
            else done = 1;
            cyc++;
        end
        o_timeout = !done;
        n_checks++;
        if (o_timeout) begin
            n_fail++;
            $display("FAIL op_timeout: stall still %0b after %0d cycles, required 0", stall, cyc);
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        set_nop();
        dmem_bus.dmem_ack = 0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; set_nop(); mem_read = 1; dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b, required 0", stall); end
        n_checks++; if (dmem_bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b, required 0", dmem_bus.dmem_req); end
        n_checks++;
        if ({dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_wdata} !== 34'h0) begin
            n_fail++; $display("FAIL reset_bus: got %h, required 0",
                               {dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_wdata});
        end
        n_checks++;
        if ({memtoreg_wb, reg_write_wb, halt_wb, instr_rd_wb, alu_out_wb, mem_data_wb, misalign_err} !== 39'h0) begin
            n_fail++; $display("FAIL reset_wb: got %h, required 0",
                               {memtoreg_wb, reg_write_wb, halt_wb, instr_rd_wb, alu_out_wb, mem_data_wb, misalign_err});
        end
        @(negedge clk);
        set_nop(); rst_n = 1;
    endtask

    task automatic test_alu_pass();
        run_op(0, 0, 1, 0, 0, 1, 0, 16'h1234, 16'h0, 3'd5, 16'h0, 0, 0);
        finish_op();
        n_checks++; if (o_stall_cnt != 0) begin n_fail++; $display("FAIL alu_stall: got %0d cycles, required 0", o_stall_cnt); end
        n_checks++; if (alu_out_wb !== 16'h1234) begin n_fail++; $display("FAIL alu_out_wb: got %h, required 1234", alu_out_wb); end
        n_checks++; if (reg_write_wb !== 1'b1) begin n_fail++; $display("FAIL alu_reg_write_wb: got %0b, required 1", reg_write_wb); end
        n_checks++; if (instr_rd_wb !== 3'd5) begin n_fail++; $display("FAIL alu_instr_rd_wb: got %0d, required 5", instr_rd_wb); end
    endtask

    task automatic test_word_load();
        run_op(1, 0, 1, 0, 1, 1, 0, 16'h0010, 16'h0, 3'd2, 16'hBEEF, 3, 0);
        finish_op();
        n_checks++; if (!o_req_seen || o_addr !== 15'h0008) begin n_fail++; $display("FAIL wl_addr: got %h, required 0008", o_addr); end
        n_checks++; if (o_be !== 2'b11 || o_we !== 1'b0) begin n_fail++; $display("FAIL wl_be_we: got be=%b we=%b, required be=11 we=0", o_be, o_we); end
        n_checks++; if (o_stall_cnt != 4) begin n_fail++; $display("FAIL wl_stall: got %0d cycles, required 4", o_stall_cnt); end
        n_checks++; if (o_unstable !== 1'b0) begin n_fail++; $display("FAIL wl_bus_stable: got unstable=%0b, required 0", o_unstable); end
        n_checks++; if (mem_data_wb !== 16'hBEEF) begin n_fail++; $display("FAIL wl_data: got %h, required beef", mem_data_wb); end
        n_checks++; if (dmem_bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL wl_req_drop: got %0b, required 0", dmem_bus.dmem_req); end
    endtask

    task automatic test_byte_load();
        run_op(1, 0, 0, 1, 1, 1, 0, 16'h0021, 16'h0, 3'd3, 16'h80FF, 0, 0);
        finish_op();
        n_checks++; if (o_be !== 2'b10) begin n_fail++; $display("FAIL bl_be: got %b, required 10", o_be); end
        n_checks++; if (o_stall_cnt != 1) begin n_fail++; $display("FAIL bl_stall: got %0d cycles, required 1", o_stall_cnt); end
        n_checks++; if (mem_data_wb !== 16'hFF80) begin n_fail++; $display("FAIL bl_sext: got %h, required ff80", mem_data_wb); end
        run_op(1, 0, 0, 0, 1, 1, 0, 16'h0021, 16'h0, 3'd3, 16'h80FF, 0, 0);
        finish_op();
        n_checks++; if (mem_data_wb !== 16'h0080) begin n_fail++; $display("FAIL bl_zext: got %h, required 0080", mem_data_wb); end
    endtask

    task automatic test_byte_store();
        run_op(0, 1, 0, 0, 0, 0, 0, 16'h0004, 16'h12AB, 3'd1, 16'hFFFF, 2, 0);
        finish_op();
        n_checks++; if (o_we !== 1'b1 || o_be !== 2'b01) begin n_fail++; $display("FAIL bs_we_be: got we=%b be=%b, required we=1 be=01", o_we, o_be); end
        n_checks++; if (o_wdata !== 16'hABAB) begin n_fail++; $display("FAIL bs_wdata: got %h, required abab", o_wdata); end
        n_checks++; if (reg_write_wb !== 1'b0 || mem_data_wb !== 16'h0) begin n_fail++; $display("FAIL bs_wb: got rw=%b data=%h, required rw=0 data=0", reg_write_wb, mem_data_wb); end
    endtask

    task automatic test_misalign();
        run_op(1, 0, 1, 0, 1, 1, 0, 16'h0003, 16'h0, 3'd4, 16'h5555, 0, 0);
        finish_op();
        n_checks++; if (o_req_seen || o_stall_cnt != 0) begin n_fail++; $display("FAIL ma_no_access: got req=%b stall_cycles=%0d, required 0 0", o_req_seen, o_stall_cnt); end
        n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL ma_pulse: got %b, required 1", misalign_err); end
        n_checks++; if (reg_write_wb !== 1'b0 || memtoreg_wb !== 1'b0) begin n_fail++; $display("FAIL ma_wb_ctrl: got rw=%b mtr=%b, required 0 0", reg_write_wb, memtoreg_wb); end
        n_checks++; if (alu_out_wb !== 16'h0003) begin n_fail++; $display("FAIL ma_alu_wb: got %h, required 0003", alu_out_wb); end
        @(negedge clk); #1;
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL ma_one_pulse: got %b, required 0", misalign_err); end
    endtask

    task automatic test_back_to_back();
        run_op(1, 0, 1, 0, 1, 1, 0, 16'h0040, 16'h0, 3'd6, 16'h1111, 1, 0);
        @(negedge clk);
        dmem_bus.dmem_ack = 0;
        alu_out = 16'h0042; instr_rd = 3'd7;
        #1;
        n_checks++; if (dmem_bus.dmem_req !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got req=%b stall=%b, required 0 1", dmem_bus.dmem_req, stall); end
        n_checks++; if (mem_data_wb !== 16'h1111) begin n_fail++; $display("FAIL b2b_first: got %h, required 1111", mem_data_wb); end
        run_op(1, 0, 1, 0, 1, 1, 0, 16'h0042, 16'h0, 3'd7, 16'h2222, 2, 0);
        finish_op();
        n_checks++; if (o_stall_cnt != 2 || o_addr !== 15'h0021) begin n_fail++; $display("FAIL b2b_second_bus: got stall=%0d addr=%h, required 2 0021", o_stall_cnt, o_addr); end
        n_checks++; if (mem_data_wb !== 16'h2222 || instr_rd_wb !== 3'd7) begin n_fail++; $display("FAIL b2b_second: got %h rd=%0d, required 2222 rd=7", mem_data_wb, instr_rd_wb); end
    endtask

    task automatic test_reset_in_access();
        int guard;
        @(negedge clk);
        mem_read = 1; word_en = 1; alu_out = 16'h0080; reg_write = 1; memtoreg = 1; instr_rd = 3'd2;
        dmem_bus.dmem_ack = 0;
        guard = 0;
        while (!dmem_bus.dmem_req && guard < 8) begin @(negedge clk); guard++; end
        n_checks++; if (dmem_bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL ria_enter: got req=%b, required 1", dmem_bus.dmem_req); end
        rst_n = 0;
        @(negedge clk); #1;
        n_checks++; if (dmem_bus.dmem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL ria_drop: got req=%b stall=%b, required 0 0", dmem_bus.dmem_req, stall); end
        rst_n = 1; set_nop(); dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 16'h9999;
        @(negedge clk); #1;
        dmem_bus.dmem_ack = 0;
        n_checks++;
        if (dmem_bus.dmem_req !== 1'b0 || reg_write_wb !== 1'b0 || mem_data_wb !== 16'h0) begin
            n_fail++; $display("FAIL ria_late_ack: got req=%b rw=%b data=%h, required 0 0 0000",
                               dmem_bus.dmem_req, reg_write_wb, mem_data_wb);
        end
    endtask

    task automatic test_random();
        logic mr, mw, wen, lde, mtr, rw, hlt, idle_ack, access, mis;
        logic [15:0] addr, rout, rdata, e_data;
        logic [2:0] rd;
        int kind, lat;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 3));
            mr = (kind == 1) || (kind == 3); mw = (kind == 2) || (kind == 3);
            wen = 1'($urandom); lde = 1'($urandom); mtr = 1'($urandom); rw = 1'($urandom); hlt = 1'($urandom);
            addr = 16'($urandom); rout = 16'($urandom); rdata = 16'($urandom); rd = 3'($urandom);
            lat = int'($urandom_range(0, 4)); idle_ack = 1'($urandom);
            mis = (mr || mw) && wen && addr[0];
            access = (mr || mw) && !mis;
            e_data = (access && mr && !mw) ? model_load(rdata, addr, wen, lde) : 16'h0;
            run_op(mr, mw, wen, lde, mtr, rw, hlt, addr, rout, rd, rdata, lat, idle_ack);
            finish_op();
            n_checks++;
            if (o_stall_cnt != (access ? lat + 1 : 0) || o_req_seen !== access) begin
                n_fail++; $display("FAIL rnd_stall[%0d]: got %0d req=%b, required %0d req=%b", i, o_stall_cnt, o_req_seen, access ? lat + 1 : 0, access);
            end
            if (access) begin
                n_checks++;
                if (o_we !== mw || o_addr !== addr[15:1] || o_be !== (wen ? 2'b11 : (addr[0] ? 2'b10 : 2'b01)) ||
                    o_wdata !== (wen ? rout : {rout[7:0], rout[7:0]}) || o_unstable) begin
                    n_fail++; $display("FAIL rnd_bus[%0d]: got we=%b addr=%h be=%b wdata=%h unstable=%b, addr in %h wen=%b rout=%h",
                                       i, o_we, o_addr, o_be, o_wdata, o_unstable, addr, wen, rout);
                end
            end
            n_checks++;
            if (mem_data_wb !== e_data || alu_out_wb !== addr || instr_rd_wb !== rd || halt_wb !== hlt ||
                reg_write_wb !== (rw && !mis) || memtoreg_wb !== (mtr && !mis) || misalign_err !== mis) begin
                n_fail++; $display("FAIL rnd_wb[%0d]: got data=%h alu=%h rd=%0d h=%b rw=%b m2r=%b mis=%b, required data=%h alu=%h rd=%0d h=%b rw=%b m2r=%b mis=%b",
                                   i, mem_data_wb, alu_out_wb, instr_rd_wb, halt_wb, reg_write_wb, memtoreg_wb, misalign_err,
                                   e_data, addr, rd, hlt, rw && !mis, mtr && !mis, mis);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_word_load();
        test_byte_load();
        test_byte_store();
        test_misalign();
        test_back_to_back();
        test_reset_in_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipeline. It sits between the EX/MEM pipeline register and the writeback stage, and consumes the registered EX/MEM control and data. It runs word and byte loads and stores against a data memory with a variable-latency req/ack handshake, and stalls the upstream pipeline while an access is outstanding. It also holds the MEM/WB pipeline register, so all writeback-facing outputs are registered.

## Interface
Parameters:
- none; data width 16, register index width 3, fixed.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  reset; synchronous, active-low.
- mem_read  in  1  load in flight from EX/MEM.
- mem_write  in  1  store in flight from EX/MEM.
- word_en  in  1  1 = 16-bit access, 0 = byte access.
- ld_en  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- memtoreg, reg_write, halt  in  1 each  control passed to writeback.
- alu_out  in  16  byte address, or ALU result for non-load writeback.
- reg_out  in  16  store data.
- instr_rd  in  3  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  15  word address, equal to alu_out[15:1].
- dmem_be  out  2  byte enables; bit0 = bits [7:0].
- dmem_wdata  out  16  write data.
- dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  16  read data.
- stall  out  1  combinational; holds EX/MEM and all earlier stages.
- memtoreg_wb, reg_write_wb, halt_wb  out  1 each  registered control.
- instr_rd_wb  out  3  registered destination.
- alu_out_wb  out  16  registered ALU result.
- mem_data_wb  out  16  registered, aligned and extended load data.
- misalign_err  out  1  one-cycle pulse on a word access with alu_out[0]=1.

## Operation
- State machine with two states, IDLE and ACCESS; reset state is IDLE.
- An access is a cycle where (mem_read | mem_write) is true and the access is aligned. A byte access is always aligned; a word access is aligned when alu_out[0] = 0.
- IDLE, access present:
  - stall = 1.
  - Register dmem_req = 1, dmem_we = mem_write, dmem_addr, dmem_be and dmem_wdata.
  - Next state is ACCESS.
  - WB register loads a bubble: reg_write_wb, memtoreg_wb and halt_wb = 0.
- IDLE, no access: no stall. WB register captures the inputs; mem_data_wb = 0.
- IDLE, misaligned word access:
  - No bus access and no stall.
  - WB register captures the inputs, with reg_write_wb forced to 0 and memtoreg_wb forced to 0.
  - misalign_err = 1 for the following cycle.
- ACCESS, dmem_ack = 0: stall = 1, bus outputs held stable, WB register loads a bubble.
- ACCESS, dmem_ack = 1:
  - stall = 0.
  - WB register captures the inputs, and mem_data_wb captures the aligned dmem_rdata.
  - dmem_req is cleared; next state is IDLE.
- Byte enables and write data:
  - Word access: be = 2'b11, wdata = reg_out.
  - Byte access: be = 2'b01 when alu_out[0] = 0, 2'b10 when alu_out[0] = 1; wdata = {reg_out[7:0], reg_out[7:0]}.
- Load alignment:
  - Word load: data = rdata.
  - Byte load: select rdata[7:0] when addr[0] = 0, rdata[15:8] when addr[0] = 1; sign-extend when ld_en = 1, else zero-extend.
- Stores: mem_data_wb = 0.
- mem_read and mem_write both high: treated as a write.
- dmem_ack in IDLE is ignored.

## Timing
- Reset (rst_n low at a clock edge) sets:
  - state IDLE;
  - dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata all 0;
  - all *_wb outputs 0;
  - misalign_err 0.
- stall is 0 while rst_n is low.
- Reset during ACCESS drops dmem_req at that edge. A late ack is ignored.
- Non-memory instruction: WB outputs valid 1 cycle after it is presented, with no stall.
- Memory access with ack arriving N cycles after dmem_req rises (N ≥ 0):
  - stall is high for N+1 cycles;
  - WB outputs are valid N+2 cycles after the instruction is presented;
  - minimum is 1 stall cycle.
- Bus outputs change only at the edge entering ACCESS and the edge leaving it.
- Back-to-back accesses: the next access is detected in IDLE on the cycle after completion, so dmem_req has exactly one low cycle between accesses.

## Structure
- Shared package mips_pkg holds:
  - state encoding MEM_IDLE = 1'b0, MEM_ACCESS = 1'b1;
  - byte-enable constants BE_WORD = 2'b11, BE_LO = 2'b01, BE_HI = 2'b10.
- One combinational sub-module, load_align: inputs rdata, addr0, word_en and ld_en; output 16-bit aligned data.
- Everything else, including the FSM, bus registers and WB register, lives in mem_stage.

## Test plan
- Reset: drive rst_n = 0 for 2 cycles with mem_read = 1 → all outputs 0, stall = 0, dmem_req = 0.
- ALU pass-through: alu_out = 16'h1234, reg_write = 1, instr_rd = 5, no memory op → next cycle alu_out_wb = 16'h1234, reg_write_wb = 1, instr_rd_wb = 5, stall never high.
- Word load, ack after 3 cycles:
  - Stimulus: alu_out = 16'h0010, rdata = 16'hBEEF.
  - Bus: dmem_addr = 15'h0008, be = 2'b11.
  - stall is high for 4 cycles, then mem_data_wb = 16'hBEEF.
- Byte load with sign extension: addr = 16'h0021, ld_en = 1, rdata = 16'h80FF, ack immediate → be = 2'b10, mem_data_wb = 16'hFF80. Repeat with ld_en = 0 → mem_data_wb = 16'h0080.
- Byte store: addr = 16'h0004, reg_out = 16'h12AB → dmem_we = 1, be = 2'b01, wdata = 16'hABAB, reg_write_wb = 0.
- Misaligned word load at addr 16'h0003 → dmem_req stays 0, stall stays 0, misalign_err pulses once, reg_write_wb = 0.
- Reset in ACCESS: assert rst_n = 0 during ACCESS, then ack → dmem_req is 0 after the edge, no WB write.
